// File: rtl/nx_node_decoder.sv
// ----------------------------------------------------------------------------
// nx_node_decoder
// Inbound message decoder for a mesh node, feeding nx_node_control.
// Each accepted message is classified by its command field:
//   cmd 0 LOAD_INSTR : payload LSBs are offered on a ready/valid instruction port
//   cmd 1 MAP_IO     : fields are registered and map_valid_o pulses for one cycle
//   cmd 2 SIG_STATE  : fields are registered and signal_valid_o pulses for one cycle
//   cmd 3 / wrong node address : message dropped, drop_count_o saturates at 255
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   node_row_i, node_col_i            this node's mesh address
//   msg_data_i/msg_valid_i/msg_ready_o   inbound message stream
//   instr_data_o/instr_valid_o/instr_ready_i  instruction load port
//   map_*_o, map_valid_o              I/O-mapping command toward nx_node_control
//   signal_*_o, signal_valid_o        signal-state command toward nx_node_control
//   drop_count_o                      saturating dropped-message counter
// ----------------------------------------------------------------------------
module nx_node_decoder #(
    parameter int STREAM_WIDTH   = 32,
    parameter int ADDR_ROW_WIDTH = 4,
    parameter int ADDR_COL_WIDTH = 4,
    parameter int COMMAND_WIDTH  = 2,
    parameter int INSTR_WIDTH    = 15,
    parameter int INPUTS         = 8,
    parameter int OUTPUTS        = 8,
    parameter int MAX_IO         = (INPUTS > OUTPUTS) ? INPUTS : OUTPUTS,
    parameter int IO_W           = $clog2(MAX_IO),
    parameter int IDX_W          = $clog2(OUTPUTS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_ROW_WIDTH-1:0] node_row_i,
    input  logic [ADDR_COL_WIDTH-1:0] node_col_i,
    input  logic [STREAM_WIDTH-1:0]   msg_data_i,
    input  logic                      msg_valid_i,
    output logic                      msg_ready_o,
    output logic [INSTR_WIDTH-1:0]    instr_data_o,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [IO_W-1:0]           map_io_o,
    output logic                      map_input_o,
    output logic [ADDR_ROW_WIDTH-1:0] map_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] map_remote_col_o,
    output logic [IDX_W-1:0]          map_remote_idx_o,
    output logic                      map_slot_o,
    output logic                      map_broadcast_o,
    output logic                      map_seq_o,
    output logic                      map_valid_o,
    output logic [ADDR_ROW_WIDTH-1:0] signal_remote_row_o,
    output logic [ADDR_COL_WIDTH-1:0] signal_remote_col_o,
    output logic [IDX_W-1:0]          signal_remote_idx_o,
    output logic                      signal_state_o,
    output logic                      signal_valid_o,
    output logic [7:0]                drop_count_o
);

    localparam int P = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH;

    // MAP_IO payload field positions, packed from the payload MSB downward
    localparam int M_IO_LO   = P - IO_W;
    localparam int M_IN      = M_IO_LO - 1;
    localparam int M_RROW_LO = M_IN - ADDR_ROW_WIDTH;
    localparam int M_RCOL_LO = M_RROW_LO - ADDR_COL_WIDTH;
    localparam int M_RIDX_LO = M_RCOL_LO - IDX_W;
    localparam int M_SLOT    = M_RIDX_LO - 1;
    localparam int M_BCAST   = M_SLOT - 1;
    localparam int M_SEQ     = M_BCAST - 1;

    // SIG_STATE payload field positions
    localparam int S_RROW_LO = P - ADDR_ROW_WIDTH;
    localparam int S_RCOL_LO = S_RROW_LO - ADDR_COL_WIDTH;
    localparam int S_RIDX_LO = S_RCOL_LO - IDX_W;
    localparam int S_STATE   = S_RIDX_LO - 1;

    localparam logic [COMMAND_WIDTH-1:0] CMD_LOAD = COMMAND_WIDTH'(0);
    localparam logic [COMMAND_WIDTH-1:0] CMD_MAP  = COMMAND_WIDTH'(1);
    localparam logic [COMMAND_WIDTH-1:0] CMD_SIG  = COMMAND_WIDTH'(2);

    // Message field split
    logic [ADDR_ROW_WIDTH-1:0] msg_row_s;
    logic [ADDR_COL_WIDTH-1:0] msg_col_s;
    logic [COMMAND_WIDTH-1:0]  msg_cmd_s;
    logic [P-1:0]              payload_s;

    assign msg_row_s = msg_data_i[STREAM_WIDTH-1 -: ADDR_ROW_WIDTH];
    assign msg_col_s = msg_data_i[STREAM_WIDTH-ADDR_ROW_WIDTH-1 -: ADDR_COL_WIDTH];
    assign msg_cmd_s = msg_data_i[P +: COMMAND_WIDTH];
    assign payload_s = msg_data_i[P-1:0];

    // Registered state
    logic [INSTR_WIDTH-1:0]    instr_data_q,   instr_data_d;
    logic                      instr_valid_q,  instr_valid_d;
    logic [IO_W-1:0]           map_io_q,       map_io_d;
    logic                      map_input_q,    map_input_d;
    logic [ADDR_ROW_WIDTH-1:0] map_rrow_q,     map_rrow_d;
    logic [ADDR_COL_WIDTH-1:0] map_rcol_q,     map_rcol_d;
    logic [IDX_W-1:0]          map_ridx_q,     map_ridx_d;
    logic                      map_slot_q,     map_slot_d;
    logic                      map_bcast_q,    map_bcast_d;
    logic                      map_seq_q,      map_seq_d;
    logic                      map_valid_q,    map_valid_d;
    logic [ADDR_ROW_WIDTH-1:0] sig_rrow_q,     sig_rrow_d;
    logic [ADDR_COL_WIDTH-1:0] sig_rcol_q,     sig_rcol_d;
    logic [IDX_W-1:0]          sig_ridx_q,     sig_ridx_d;
    logic                      sig_state_q,    sig_state_d;
    logic                      sig_valid_q,    sig_valid_d;
    logic [7:0]                drop_count_q,   drop_count_d;

    logic accept_s;
    logic match_s;
    logic load_fire_s;
    logic map_fire_s;
    logic sig_fire_s;
    logic drop_fire_s;

    // A pending instruction blocks the stream until the store takes it;
    // the take and a new acceptance may happen in the same cycle.
    assign msg_ready_o = !instr_valid_q || instr_ready_i;
    assign accept_s    = msg_valid_i && msg_ready_o;
    assign match_s     = (msg_row_s == node_row_i) && (msg_col_s == node_col_i);

    // Classify the accepted message into exactly one action
    always_comb begin
        load_fire_s = 1'b0;
        map_fire_s  = 1'b0;
        sig_fire_s  = 1'b0;
        drop_fire_s = 1'b0;
        if (accept_s) begin
            if (!match_s) begin
                drop_fire_s = 1'b1;
            end else begin
                case (msg_cmd_s)
                    CMD_LOAD: load_fire_s = 1'b1;
                    CMD_MAP:  map_fire_s  = 1'b1;
                    CMD_SIG:  sig_fire_s  = 1'b1;
                    default:  drop_fire_s = 1'b1;
                endcase
            end
        end else begin
            drop_fire_s = 1'b0;
        end
    end

    // Next-state for the instruction port, field registers and drop counter
    always_comb begin
        instr_data_d  = instr_data_q;
        instr_valid_d = instr_valid_q;
        map_io_d      = map_io_q;
        map_input_d   = map_input_q;
        map_rrow_d    = map_rrow_q;
        map_rcol_d    = map_rcol_q;
        map_ridx_d    = map_ridx_q;
        map_slot_d    = map_slot_q;
        map_bcast_d   = map_bcast_q;
        map_seq_d     = map_seq_q;
        sig_rrow_d    = sig_rrow_q;
        sig_rcol_d    = sig_rcol_q;
        sig_ridx_d    = sig_ridx_q;
        sig_state_d   = sig_state_q;
        drop_count_d  = drop_count_q;
        map_valid_d   = map_fire_s;
        sig_valid_d   = sig_fire_s;

        if (load_fire_s) begin
            instr_data_d  = payload_s[INSTR_WIDTH-1:0];
            instr_valid_d = 1'b1;
        end else if (instr_ready_i) begin
            instr_valid_d = 1'b0;
        end else begin
            instr_valid_d = instr_valid_q;
        end

        if (map_fire_s) begin
            map_io_d    = payload_s[M_IO_LO +: IO_W];
            map_input_d = payload_s[M_IN];
            map_rrow_d  = payload_s[M_RROW_LO +: ADDR_ROW_WIDTH];
            map_rcol_d  = payload_s[M_RCOL_LO +: ADDR_COL_WIDTH];
            map_ridx_d  = payload_s[M_RIDX_LO +: IDX_W];
            map_slot_d  = payload_s[M_SLOT];
            map_bcast_d = payload_s[M_BCAST];
            map_seq_d   = payload_s[M_SEQ];
        end else begin
            map_io_d    = map_io_q;
        end

        if (sig_fire_s) begin
            sig_rrow_d  = payload_s[S_RROW_LO +: ADDR_ROW_WIDTH];
            sig_rcol_d  = payload_s[S_RCOL_LO +: ADDR_COL_WIDTH];
            sig_ridx_d  = payload_s[S_RIDX_LO +: IDX_W];
            sig_state_d = payload_s[S_STATE];
        end else begin
            sig_state_d = sig_state_q;
        end

        // Saturate rather than wrap so a flood of bad traffic stays visible
        if (drop_fire_s && (drop_count_q != 8'hFF)) begin
            drop_count_d = drop_count_q + 8'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // State registers with synchronous reset; reset discards any pending instruction
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_data_q  <= '0;
            instr_valid_q <= 1'b0;
            map_io_q      <= '0;
            map_input_q   <= 1'b0;
            map_rrow_q    <= '0;
            map_rcol_q    <= '0;
            map_ridx_q    <= '0;
            map_slot_q    <= 1'b0;
            map_bcast_q   <= 1'b0;
            map_seq_q     <= 1'b0;
            map_valid_q   <= 1'b0;
            sig_rrow_q    <= '0;
            sig_rcol_q    <= '0;
            sig_ridx_q    <= '0;
            sig_state_q   <= 1'b0;
            sig_valid_q   <= 1'b0;
            drop_count_q  <= 8'd0;
        end else begin
            instr_data_q  <= instr_data_d;
            instr_valid_q <= instr_valid_d;
            map_io_q      <= map_io_d;
            map_input_q   <= map_input_d;
            map_rrow_q    <= map_rrow_d;
            map_rcol_q    <= map_rcol_d;
            map_ridx_q    <= map_ridx_d;
            map_slot_q    <= map_slot_d;
            map_bcast_q   <= map_bcast_d;
            map_seq_q     <= map_seq_d;
            map_valid_q   <= map_valid_d;
            sig_rrow_q    <= sig_rrow_d;
            sig_rcol_q    <= sig_rcol_d;
            sig_ridx_q    <= sig_ridx_d;
            sig_state_q   <= sig_state_d;
            sig_valid_q   <= sig_valid_d;
            drop_count_q  <= drop_count_d;
        end
    end

    assign instr_data_o        = instr_data_q;
    assign instr_valid_o       = instr_valid_q;
    assign map_io_o            = map_io_q;
    assign map_input_o         = map_input_q;
    assign map_remote_row_o    = map_rrow_q;
    assign map_remote_col_o    = map_rcol_q;
    assign map_remote_idx_o    = map_ridx_q;
    assign map_slot_o          = map_slot_q;
    assign map_broadcast_o     = map_bcast_q;
    assign map_seq_o           = map_seq_q;
    assign map_valid_o         = map_valid_q;
    assign signal_remote_row_o = sig_rrow_q;
    assign signal_remote_col_o = sig_rcol_q;
    assign signal_remote_idx_o = sig_ridx_q;
    assign signal_state_o      = sig_state_q;
    assign signal_valid_o      = sig_valid_q;
    assign drop_count_o        = drop_count_q;

endmodule

// File: tb/tb_nx_node_decoder.sv
// ----------------------------------------------------------------------------
// tb_nx_node_decoder
// Directed bench for nx_node_decoder with the node at row 2, column 3.
// Inputs are driven right after the falling edge and outputs are checked at
// the falling edge, half a cycle away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_nx_node_decoder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  node_row_i;
    logic [3:0]  node_col_i;
    logic [31:0] msg_data_i;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [14:0] instr_data_o;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [2:0]  map_io_o;
    logic        map_input_o;
    logic [3:0]  map_remote_row_o;
    logic [3:0]  map_remote_col_o;
    logic [2:0]  map_remote_idx_o;
    logic        map_slot_o;
    logic        map_broadcast_o;
    logic        map_seq_o;
    logic        map_valid_o;
    logic [3:0]  signal_remote_row_o;
    logic [3:0]  signal_remote_col_o;
    logic [2:0]  signal_remote_idx_o;
    logic        signal_state_o;
    logic        signal_valid_o;
    logic [7:0]  drop_count_o;

    int errors = 0;
    int checks = 0;

    nx_node_decoder dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .node_row_i          (node_row_i),
        .node_col_i          (node_col_i),
        .msg_data_i          (msg_data_i),
        .msg_valid_i         (msg_valid_i),
        .msg_ready_o         (msg_ready_o),
        .instr_data_o        (instr_data_o),
        .instr_valid_o       (instr_valid_o),
        .instr_ready_i       (instr_ready_i),
        .map_io_o            (map_io_o),
        .map_input_o         (map_input_o),
        .map_remote_row_o    (map_remote_row_o),
        .map_remote_col_o    (map_remote_col_o),
        .map_remote_idx_o    (map_remote_idx_o),
        .map_slot_o          (map_slot_o),
        .map_broadcast_o     (map_broadcast_o),
        .map_seq_o           (map_seq_o),
        .map_valid_o         (map_valid_o),
        .signal_remote_row_o (signal_remote_row_o),
        .signal_remote_col_o (signal_remote_col_o),
        .signal_remote_idx_o (signal_remote_idx_o),
        .signal_state_o      (signal_state_o),
        .signal_valid_o      (signal_valid_o),
        .drop_count_o        (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one message for exactly one rising edge, then drop valid
    task automatic send(input logic [31:0] d);
        msg_data_i  = d;
        msg_valid_i = 1'b1;
        @(negedge clk_i);
        msg_valid_i = 1'b0;
    endtask

    initial begin
        rst_i         = 1'b1;
        node_row_i    = 4'd2;
        node_col_i    = 4'd3;
        msg_data_i    = 32'h0;
        msg_valid_i   = 1'b0;
        instr_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // Reset state
        chk("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_map_valid",   {31'd0, map_valid_o},   32'd0);
        chk("rst_sig_valid",   {31'd0, signal_valid_o}, 32'd0);
        chk("rst_drop_count",  {24'd0, drop_count_o},  32'd0);
        chk("rst_instr_data",  {17'd0, instr_data_o},  32'd0);
        rst_i = 1'b0;
        #1;
        chk("rst_msg_ready",   {31'd0, msg_ready_o},   32'd1);
        @(negedge clk_i);

        // MAP_IO decode
        send(32'h236DA550);
        chk("map_valid",  {31'd0, map_valid_o},      32'd1);
        chk("map_io",     {29'd0, map_io_o},         32'd5);
        chk("map_input",  {31'd0, map_input_o},      32'd1);
        chk("map_row",    {28'd0, map_remote_row_o}, 32'd6);
        chk("map_col",    {28'd0, map_remote_col_o}, 32'd9);
        chk("map_idx",    {29'd0, map_remote_idx_o}, 32'd2);
        chk("map_slot",   {31'd0, map_slot_o},       32'd1);
        chk("map_bcast",  {31'd0, map_broadcast_o},  32'd0);
        chk("map_seq",    {31'd0, map_seq_o},        32'd1);
        chk("map_sigv",   {31'd0, signal_valid_o},   32'd0);
        @(negedge clk_i);
        chk("map_pulse_end", {31'd0, map_valid_o},   32'd0);

        // SIG_STATE decode
        send(32'h2385E400);
        chk("sig_valid",  {31'd0, signal_valid_o},      32'd1);
        chk("sig_row",    {28'd0, signal_remote_row_o}, 32'd1);
        chk("sig_col",    {28'd0, signal_remote_col_o}, 32'd7);
        chk("sig_idx",    {29'd0, signal_remote_idx_o}, 32'd4);
        chk("sig_state",  {31'd0, signal_state_o},      32'd1);
        chk("sig_mapv",   {31'd0, map_valid_o},         32'd0);
        chk("sig_drops",  {24'd0, drop_count_o},        32'd0);
        @(negedge clk_i);
        chk("sig_pulse_end", {31'd0, signal_valid_o},   32'd0);

        // Instruction load with a 3-cycle stall; a MAP is offered but must wait
        instr_ready_i = 1'b0;
        send(32'h23001234);
        chk("ld_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("ld_data",  {17'd0, instr_data_o},  32'h1234);
        chk("ld_ready", {31'd0, msg_ready_o},   32'd0);
        msg_data_i  = 32'h236DA550;
        msg_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("stall_valid", {31'd0, instr_valid_o}, 32'd1);
            chk("stall_data",  {17'd0, instr_data_o},  32'h1234);
            chk("stall_ready", {31'd0, msg_ready_o},   32'd0);
            chk("stall_mapv",  {31'd0, map_valid_o},   32'd0);
        end
        msg_valid_i   = 1'b0;
        instr_ready_i = 1'b1;
        #1;
        chk("take_ready_comb", {31'd0, msg_ready_o}, 32'd1);
        @(negedge clk_i);
        chk("take_valid_drop", {31'd0, instr_valid_o}, 32'd0);

        // Take and accept a new instruction in the same cycle
        instr_ready_i = 1'b0;
        send(32'h23001234);
        chk("ld2_valid", {31'd0, instr_valid_o}, 32'd1);
        instr_ready_i = 1'b1;
        send(32'h23005678);
        chk("b2b_ld_valid", {31'd0, instr_valid_o}, 32'd1);
        chk("b2b_ld_data",  {17'd0, instr_data_o},  32'h5678);
        @(negedge clk_i);
        chk("b2b_ld_done",  {31'd0, instr_valid_o}, 32'd0);

        // Drops: wrong address, then reserved command
        send(32'h45001234);
        chk("drop1_count", {24'd0, drop_count_o}, 32'd1);
        chk("drop1_valids", {29'd0, map_valid_o, signal_valid_o, instr_valid_o}, 32'd0);
        send(32'h23C00000);
        chk("drop2_count", {24'd0, drop_count_o}, 32'd2);
        chk("drop2_valids", {29'd0, map_valid_o, signal_valid_o, instr_valid_o}, 32'd0);
        for (int i = 0; i < 298; i++) begin
            send(32'h45001234);
        end
        chk("drop_sat_255", {24'd0, drop_count_o}, 32'd255);
        send(32'h23C00000);
        chk("drop_sat_hold", {24'd0, drop_count_o}, 32'd255);

        // Back-to-back MAP, SIG, MAP
        send(32'h236DA550);
        chk("b2b_map1", {31'd0, map_valid_o},    32'd1);
        send(32'h2385E400);
        chk("b2b_sig",  {31'd0, signal_valid_o}, 32'd1);
        chk("b2b_sig_mapv", {31'd0, map_valid_o}, 32'd0);
        send(32'h23400010);
        chk("b2b_map2",     {31'd0, map_valid_o},    32'd1);
        chk("b2b_map2_io",  {29'd0, map_io_o},       32'd0);
        chk("b2b_map2_seq", {31'd0, map_seq_o},      32'd1);
        chk("b2b_map2_sigv", {31'd0, signal_valid_o}, 32'd0);
        @(negedge clk_i);
        chk("b2b_end", {30'd0, map_valid_o, signal_valid_o}, 32'd0);

        // Reset during an instruction stall
        instr_ready_i = 1'b0;
        send(32'h23001234);
        chk("rst_stall_pre", {31'd0, instr_valid_o}, 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_stall_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_stall_drops", {24'd0, drop_count_o},  32'd0);
        chk("rst_stall_ready", {31'd0, msg_ready_o},   32'd1);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_ready", {31'd0, msg_ready_o},   32'd1);
        chk("post_rst_valid", {31'd0, instr_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
